spi_slave_mode: RTL



---
 rtl/spi_slave_mode.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_mode.sv
// Full-duplex SPI slave with synchronised SCLK/SS_n/MOSI, all four CPOL/CPHA modes,
// selectable bit order and a one-deep TX holding register with valid/ready handshake.
module spi_slave_mode #(
    parameter int FRAME_WIDTH = 10,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SCLK,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic                   miso_oe,
    output logic                   rx_valid,
    output logic [FRAME_WIDTH-1:0] rx_data,
    input  logic                   tx_valid,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   tx_underrun,
    output logic                   frame_abort
);

    localparam int               CNT_W    = $clog2(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);
    localparam logic             IDLE_LVL = (CPOL != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_prev_reg;
    logic                   ss_prev_reg;

    logic [1:0]             state_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [FRAME_WIDTH-1:0] tx_shift_reg;
    logic [FRAME_WIDTH-1:0] rx_shift_reg;
    logic [FRAME_WIDTH-1:0] hold_reg;
    logic                   hold_full_reg;
    logic [FRAME_WIDTH-1:0] rx_data_reg;
    logic                   miso_reg;
    logic                   rx_valid_reg;
    logic                   underrun_reg;
    logic                   abort_reg;

    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   leading_edge;
    logic                   trailing_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   shift_enable;
    logic [FRAME_WIDTH-1:0] tx_src;
    logic [FRAME_WIDTH-1:0] rx_next;

    function automatic logic first_bit(input logic [FRAME_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[FRAME_WIDTH-1];
    endfunction

    function automatic logic [FRAME_WIDTH-1:0] advance(input logic [FRAME_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        sclk_s        = sclk_sync_reg[SYNC_STAGES-1];
        ss_s          = ss_sync_reg[SYNC_STAGES-1];
        mosi_s        = mosi_sync_reg[SYNC_STAGES-1];
        sclk_rise     = sclk_s & ~sclk_prev_reg;
        sclk_fall     = ~sclk_s & sclk_prev_reg;
        leading_edge  = (CPOL != 0) ? sclk_fall : sclk_rise;
        trailing_edge = (CPOL != 0) ? sclk_rise : sclk_fall;
        sample_edge   = (CPHA != 0) ? trailing_edge : leading_edge;
        shift_edge    = (CPHA != 0) ? leading_edge : trailing_edge;
        // In CPHA=0 the trailing edge that follows the final sample lands at count 0
        // of the next frame and must not disturb the freshly loaded first bit.
        shift_enable  = shift_edge && ((CPHA != 0) || (bit_cnt_reg != '0));
        tx_src        = hold_full_reg ? hold_reg : '0;
        rx_next       = (LSB_FIRST != 0) ? {mosi_s, rx_shift_reg[FRAME_WIDTH-1:1]}
                                         : {rx_shift_reg[FRAME_WIDTH-2:0], mosi_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_reg <= {SYNC_STAGES{IDLE_LVL}};
            ss_sync_reg   <= {SYNC_STAGES{1'b1}};
            mosi_sync_reg <= '0;
            sclk_prev_reg <= IDLE_LVL;
            ss_prev_reg   <= 1'b1;
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            rx_data_reg   <= '0;
            miso_reg      <= 1'b0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], SS_n};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
            sclk_prev_reg <= sclk_s;
            ss_prev_reg   <= ss_s;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            abort_reg     <= 1'b0;

            // Accept only while empty; LOAD consumes only while full, so the two never collide.
            if (tx_valid && !hold_full_reg) begin
                hold_reg      <= tx_data;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    miso_reg <= 1'b0;
                    if (ss_prev_reg && !ss_s) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ss_s) begin
                        miso_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        bit_cnt_reg <= '0;
                        if (hold_full_reg) begin
                            hold_full_reg <= 1'b0;
                        end else begin
                            underrun_reg <= 1'b1;
                        end
                        if (CPHA == 0) begin
                            miso_reg     <= first_bit(tx_src);
                            tx_shift_reg <= advance(tx_src);
                        end else begin
                            tx_shift_reg <= tx_src;
                        end
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sample_edge && (bit_cnt_reg == LAST_BIT)) begin
                        rx_shift_reg <= rx_next;
                        rx_data_reg  <= rx_next;
                        rx_valid_reg <= 1'b1;
                        if (ss_s) begin
                            miso_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_LOAD;
                        end
                    end else if (ss_s) begin
                        abort_reg <= (bit_cnt_reg != '0);
                        miso_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_reg <= rx_next;
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        end
                        if (shift_enable) begin
                            miso_reg     <= first_bit(tx_shift_reg);
                            tx_shift_reg <= advance(tx_shift_reg);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign MISO        = miso_reg;
    assign miso_oe     = ~ss_s;
    assign rx_valid    = rx_valid_reg;
    assign rx_data     = rx_data_reg;
    assign tx_ready    = ~hold_full_reg;
    assign tx_underrun = underrun_reg;
    assign frame_abort = abort_reg;

endmodule
